// File: rtl/dly_multi.sv
// Multi-channel pulse delay generator: each trigger yields an output pulse
// DELAY ticks later, WIDTH ticks wide, with counter or shift-line timing per channel.
module dly_multi #(
  parameter int CHANNELS = 4,
  parameter int DELAY    = 4,
  parameter int WIDTH    = 1,
  parameter int MODE     = 0,
  parameter int SYNC     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] abort,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] level
);

  logic [CHANNELS-1:0] trig;

  generate
    if (SYNC != 0) begin : g_sync
      logic [CHANNELS-1:0] s1, s2, s3, armed;
      logic                vld;

      // armed only once the synchronised input has been seen low after reset,
      // so a level already high at reset release never counts as a rising edge
      always_ff @(posedge clk) begin
        if (reset) begin
          s1    <= '0;
          s2    <= '0;
          s3    <= '0;
          armed <= '0;
          vld   <= 1'b0;
        end else begin
          s1  <= in;
          s2  <= s1;
          s3  <= s2;
          vld <= 1'b1;
          if (vld) armed <= armed | ~s1;
        end
      end

      assign trig = s2 & ~s3 & armed;
    end else begin : g_nosync
      assign trig = in;
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      if (MODE == 2) begin : g_shift
        localparam int LEN = DELAY + WIDTH - 1;
        logic [LEN-1:0] sh, sh_nx;
        logic           lvl_nx, out_nx;
        logic           out_q, lvl_q;

        // stage k of sh_nx is the trigger that will be k+1 cycles old next cycle
        always_comb begin
          sh_nx = LEN'({sh, trig[ch]});
        end

        if (DELAY > 1) begin : g_lv
          assign lvl_nx = |sh_nx[DELAY-2:0];
        end else begin : g_nolv
          assign lvl_nx = 1'b0;
        end
        assign out_nx = |sh_nx[LEN-1:DELAY-1];

        always_ff @(posedge clk) begin
          if (reset || abort[ch]) begin
            sh    <= '0;
            out_q <= 1'b0;
            lvl_q <= 1'b0;
          end else begin
            sh    <= sh_nx;
            out_q <= out_nx;
            lvl_q <= lvl_nx;
          end
        end

        assign out[ch]   = out_q;
        assign level[ch] = lvl_q;
      end else begin : g_count
        localparam int CW = $clog2(DELAY + 1);
        localparam logic [CW-1:0] LAST = CW'(DELAY - 1);
        logic [CW-1:0] cnt;
        logic [7:0]    wrem;
        logic          pend, out_q, accept, start;

        // MODE 1 lets a trigger restart a pending delay; MODE 0 drops it
        always_comb begin
          accept = trig[ch] && (!pend || (MODE == 1));
          start  = 1'b0;
          if (accept && (DELAY == 1))
            start = 1'b1;
          else if (pend && !accept && (cnt == LAST))
            start = 1'b1;
        end

        // a new pulse reloads the width count, which ORs it with any running one
        always_ff @(posedge clk) begin
          if (reset || abort[ch]) begin
            cnt   <= '0;
            pend  <= 1'b0;
            wrem  <= '0;
            out_q <= 1'b0;
          end else begin
            if (accept && (DELAY > 1)) begin
              pend <= 1'b1;
              cnt  <= CW'(1);
            end else if (pend) begin
              if (cnt == LAST) pend <= 1'b0;
              else cnt <= cnt + 1'b1;
            end
            if (start) begin
              out_q <= 1'b1;
              wrem  <= 8'(WIDTH - 1);
            end else if (out_q) begin
              if (wrem == 8'd0) out_q <= 1'b0;
              else wrem <= wrem - 1'b1;
            end
          end
        end

        assign out[ch]   = out_q;
        assign level[ch] = pend;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dly_multi.sv
// Scoreboard bench for dly_multi: several parameterisations run side by side,
// expected {out,level} per cycle queued by stimulus and checked by a monitor.
module tb_dly_multi;

  localparam int NDUT = 9;
  localparam int NCYC = 100;

  typedef struct packed {
    logic [NDUT-1:0][7:0] v;
    int                   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, reset_e2;
  logic [3:0] in_a, in_b, in_c, in_d, abort_d, in_e, in_f, abort_f, no_abort;
  logic [3:0] out_a, lvl_a, out_b0, lvl_b0, out_b1, lvl_b1, out_b2, lvl_b2;
  logic [3:0] out_c, lvl_c, out_d, lvl_d, out_e, lvl_e, out_e2, lvl_e2, out_f, lvl_f;
  logic [7:0] act [NDUT];
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  bit stim_done = 1'b0;

  always #5 clk = ~clk;

  dly_multi #(.CHANNELS(4), .DELAY(4), .WIDTH(1), .MODE(0), .SYNC(0)) u_a
    (.clk(clk), .reset(reset), .in(in_a), .abort(no_abort), .out(out_a), .level(lvl_a));
  dly_multi #(.CHANNELS(4), .DELAY(8), .WIDTH(2), .MODE(0), .SYNC(0)) u_b0
    (.clk(clk), .reset(reset), .in(in_b), .abort(no_abort), .out(out_b0), .level(lvl_b0));
  dly_multi #(.CHANNELS(4), .DELAY(8), .WIDTH(2), .MODE(1), .SYNC(0)) u_b1
    (.clk(clk), .reset(reset), .in(in_b), .abort(no_abort), .out(out_b1), .level(lvl_b1));
  dly_multi #(.CHANNELS(4), .DELAY(8), .WIDTH(2), .MODE(2), .SYNC(0)) u_b2
    (.clk(clk), .reset(reset), .in(in_b), .abort(no_abort), .out(out_b2), .level(lvl_b2));
  dly_multi #(.CHANNELS(4), .DELAY(3), .WIDTH(2), .MODE(2), .SYNC(0)) u_c
    (.clk(clk), .reset(reset), .in(in_c), .abort(no_abort), .out(out_c), .level(lvl_c));
  dly_multi #(.CHANNELS(4), .DELAY(6), .WIDTH(1), .MODE(0), .SYNC(0)) u_d
    (.clk(clk), .reset(reset), .in(in_d), .abort(abort_d), .out(out_d), .level(lvl_d));
  dly_multi #(.CHANNELS(4), .DELAY(2), .WIDTH(1), .MODE(0), .SYNC(1)) u_e
    (.clk(clk), .reset(reset), .in(in_e), .abort(no_abort), .out(out_e), .level(lvl_e));
  dly_multi #(.CHANNELS(4), .DELAY(2), .WIDTH(1), .MODE(0), .SYNC(1)) u_e2
    (.clk(clk), .reset(reset_e2), .in(in_e), .abort(no_abort), .out(out_e2), .level(lvl_e2));
  dly_multi #(.CHANNELS(4), .DELAY(1), .WIDTH(3), .MODE(0), .SYNC(0)) u_f
    (.clk(clk), .reset(reset), .in(in_f), .abort(abort_f), .out(out_f), .level(lvl_f));

  assign act[0] = {out_a, lvl_a};
  assign act[1] = {out_b0, lvl_b0};
  assign act[2] = {out_b1, lvl_b1};
  assign act[3] = {out_b2, lvl_b2};
  assign act[4] = {out_c, lvl_c};
  assign act[5] = {out_d, lvl_d};
  assign act[6] = {out_e, lvl_e};
  assign act[7] = {out_e2, lvl_e2};
  assign act[8] = {out_f, lvl_f};

  function automatic bit w(int c, int a, int b);
    return (c >= a) && (c <= b);
  endfunction

  function automatic logic [7:0] pk(logic [3:0] o, logic [3:0] l);
    return {o, l};
  endfunction

  // hand-derived windows: field k is {out[3:0], level[3:0]} of DUT k in cycle c
  function automatic exp_t expected(int c);
    exp_t e;
    e.cyc  = c;
    e.v[0] = pk({2'b0, c == 24, (c == 14) || (c == 18)},
                {2'b0, w(c, 21, 23), w(c, 11, 13) || w(c, 15, 17)});
    e.v[1] = pk({2'b0, w(c, 18, 19), 1'b0}, {2'b0, w(c, 11, 17), 1'b0});
    e.v[2] = pk({2'b0, w(c, 21, 22), 1'b0}, {2'b0, w(c, 11, 20), 1'b0});
    e.v[3] = pk({2'b0, w(c, 18, 19) || w(c, 21, 22), 1'b0}, {2'b0, w(c, 11, 20), 1'b0});
    e.v[4] = pk({1'b0, w(c, 8, 11), 2'b0}, {1'b0, w(c, 6, 9), 2'b0});
    e.v[5] = pk(4'b0, {3'b0, w(c, 11, 13)});
    e.v[6] = pk({c == 33, 3'b0}, {c == 32, 3'b0});
    e.v[7] = 8'h00;
    e.v[8] = pk({3'b0, w(c, 11, 14)}, 4'b0);
    return e;
  endfunction

  task automatic apply_stimulus(input int c);
    reset      = (c <= 2);
    reset_e2   = (c <= 2) || (c == 31);
    in_a       = {2'b0, (c == 20) || (c == 21), (c == 10) || (c == 14)};
    in_b       = {2'b0, (c == 10) || (c == 13), 1'b0};
    in_c       = {1'b0, w(c, 5, 7), 2'b0};
    in_d       = {3'b0, (c == 10) || (c == 20)};
    abort_d    = {3'b0, (c == 13) || (c == 20)};
    in_e       = {w(c, 29, 79), 3'b0};
    in_f       = {3'b0, (c == 10) || (c == 12)};
    abort_f    = {3'b0, c == 14};
    if (c >= 1) sb.push_back(expected(c));
  endtask

  initial begin
    no_abort = '0;
    apply_stimulus(0);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      apply_stimulus(c);
    end
    @(posedge clk);
    stim_done = 1'b1;
  end

  // monitor: every cycle the DUTs present {out,level}; pop and compare mid-cycle
  initial begin
    exp_t e;
    int   budget;
    budget = NCYC + 20;
    while (!(stim_done && sb.size() == 0) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < NDUT; k++) begin
          total++;
          if (act[k] !== e.v[k]) begin
            bad++;
            $display("[TB] FAIL dut%0d cycle %0d {out,level}: got %b want %b",
                     k, e.cyc, act[k], e.v[k]);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0 || !stim_done) begin
      bad++;
      $display("[TB] FAIL drain: pending=%0d got stim_done=%0d want 1", sb.size(), stim_done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
